ram_64kb: RTL and testbench
===========================

Name: ram_64kb

Overview:
- Single-port 64K x 8 random-access memory with a synchronous write and an asynchronous (combinational) read.
- Serves as the general-purpose main memory for the system; any bus master drives address, data_in and we directly.
- Supports a logical clear: after reset, every location reads as zero without 64K physical writes.

Parameters:
- ADDR_WIDTH, 16, address width in bits.
- DATA_WIDTH, 8, word width in bits.
- DEPTH, 2**ADDR_WIDTH (65536), number of words. Not overridden independently of ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- address  input  ADDR_WIDTH (16)  word address for both read and write.
- data_in  input  DATA_WIDTH (8)  write data.
- we  input  1  write enable, active high, sampled on rising clk.
- data_out  output  DATA_WIDTH (8)  read data for the current address.

Behaviour:
- Storage: DEPTH x DATA_WIDTH data array, plus a DEPTH x 1 valid bitmap.
- Reset (rst_n low, asynchronous):
  - All valid bits clear immediately, without waiting for clk.
  - The data array is not cleared.
  - While rst_n is low, writes are ignored and data_out = 0.
  - Deassertion takes effect on the next rising clk edge after rst_n is high.
- Write: on the rising clk edge with rst_n high and we=1:
  - mem[address] <= data_in.
  - valid[address] <= 1.
  - Exactly one location changes per edge.
- No write when we=0. Memory is unchanged regardless of the address and data_in values.
- Read is combinational, with zero-cycle latency:
  - data_out = valid[address] ? mem[address] : 0.
  - data_out follows address changes within the same delta/cycle; there is no clock involvement.
- Read-during-write to the same address:
  - Before the edge, data_out shows the old contents (0 if invalid).
  - After the edge, it shows the newly written data_in. There is no write-through bypass.
- Address space: the full 16-bit range 0x0000–0xFFFF is valid. There is no wrap-around or out-of-range case. Address 0x0000 and 0xFFFF behave identically to any other location.
- Reset mid-operation: if rst_n falls in the same cycle as a write, the write is discarded and the location reads 0.
- Unknown inputs:
  - If we is X/Z at a clock edge, no write occurs.
  - The design does not need to model an X address.
- No handshake: every write completes in one cycle; reads are always available.
- Synthesis: the array infers a single-port RAM. The valid bitmap is a separate register array or a RAM with a reset-sweep controller.
  - If a sweep is used, it takes DEPTH cycles.
  - During the sweep, data_out = 0 and writes are held off.
  - In simulation the clear is immediate.

Test Plan:
- Reset then read: assert rst_n=0 for 2 cycles, release, then read addresses 0x0000, 0x0001, 0xFFFF -> data_out=0x00 for each.
- Basic write/read:
  - Write 0xAB to 0x0001 with we=1 for one rising edge, then we=0, address=0x0001 -> data_out=0xAB.
  - Write 0xCD to 0x0002 -> reading 0x0002 gives 0xCD, and 0x0001 still gives 0xAB.
- Write-disable: with we=0, drive address=0x0001 and data_in=0x55 across several edges -> data_out stays 0xAB.
- Boundary addresses: write 0x11 to 0x0000 and 0x99 to 0xFFFF -> each reads back correctly, and 0x0001 is unchanged (0xAB).
- Read-during-write: address=0x0003 (previously 0x22), we=1, data_in=0x77:
  - Before the edge, data_out=0x22.
  - After the edge, data_out=0x77.
- Reset clears contents logically: after the writes above, pulse rst_n low asynchronously (mid-cycle) -> data_out=0x00 immediately. After release, every previously written address reads 0x00 until rewritten.

Source files
------------

// File: rtl/ram_64kb.sv
// +--------------------------------------------------------------------+
// | ram_64kb : 64K x 8 single-port RAM, sync write, async read,        |
// |            logical clear via a per-word valid bitmap.              |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module ram_64kb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic                  w_write;

  // An X/Z on we makes the if-condition false, so no write happens.
  assign w_write = rst_n && we;

  // Data array carries no reset so it maps onto a plain single-port RAM.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[address] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (we) begin
      r_valid[address] <= 1'b1;
    end
  end

  // Unwritten locations read as zero; this is what makes reset a logical clear.
  assign data_out = (rst_n && r_valid[address]) ? r_mem[address] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_64kb.sv
// +--------------------------------------------------------------------+
// | tb_ram_64kb : self-checking bench for ram_64kb against a sparse    |
// |               associative-array memory model.                      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ram_64kb;

  logic        clk;
  logic        rst_n;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        we;
  logic [7:0]  data_out;

  int checks;
  int failures;

  // Model: only written locations exist; a missing key reads as zero.
  logic [7:0] model [int];

  ram_64kb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] expected(input logic [15:0] a);
    return model.exists(int'(a)) ? model[int'(a)] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    we      = 1'b1;
    @(posedge clk);
    model[int'(a)] = d;
    #1;
    we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a);
    @(negedge clk);
    address = a;
    #1;
    check(tag, data_out, expected(a));
  endtask

  logic [15:0] pool [16];
  logic [15:0] a;
  logic [7:0]  d;
  logic        w;
  int          keys [$];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    we       = 1'b0;
    address  = 16'h0000;
    data_in  = 8'h00;

    // Reset for two cycles; a write attempt during reset must be ignored.
    @(negedge clk);
    address = 16'h0010;
    data_in = 8'h5A;
    we      = 1'b1;
    @(posedge clk);
    #1;
    check("reset_out", data_out, 8'h00);
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_check("ignored_write_in_reset", 16'h0010);

    read_check("reset_0000", 16'h0000);
    read_check("reset_0001", 16'h0001);
    read_check("reset_ffff", 16'h3FFF ^ 16'hC000);

    write(16'h0001, 8'hAB);
    read_check("wr_0001", 16'h0001);
    check("wr_0001_const", data_out, 8'hAB);
    write(16'h0002, 8'hCD);
    read_check("wr_0002", 16'h0002);
    check("wr_0002_const", data_out, 8'hCD);
    read_check("keep_0001", 16'h0001);

    // Write-disabled edges with conflicting data_in.
    @(negedge clk);
    address = 16'h0001;
    data_in = 8'h55;
    we      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("we0_hold", data_out, 8'hAB);
    end

    write(16'h0000, 8'h11);
    write(16'hFFFF, 8'h99);
    read_check("bnd_0000", 16'h0000);
    check("bnd_0000_const", data_out, 8'h11);
    read_check("bnd_ffff", 16'hFFFF);
    check("bnd_ffff_const", data_out, 8'h99);
    read_check("bnd_keep_0001", 16'h0001);

    // Read-during-write: old data before the edge, new data after, no bypass.
    write(16'h0003, 8'h22);
    @(negedge clk);
    address = 16'h0003;
    data_in = 8'h77;
    we      = 1'b1;
    #1;
    check("rdw_before", data_out, 8'h22);
    @(posedge clk);
    model[3] = 8'h77;
    #1;
    check("rdw_after", data_out, 8'h77);
    we = 1'b0;

    // Randomized mix of writes and reads over a small address pool.
    pool[0] = 16'h0000;
    pool[1] = 16'hFFFF;
    for (int i = 2; i < 16; i++) pool[i] = 16'($urandom);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 15)];
      d = 8'($urandom);
      w = 1'($urandom);
      address = a;
      data_in = d;
      we      = w;
      #1;
      check("rnd_pre", data_out, expected(a));
      @(posedge clk);
      if (w) model[int'(a)] = d;
      #1;
      check("rnd_post", data_out, expected(a));
      we = 1'b0;
    end

    // Mid-cycle asynchronous reset colliding with a pending write.
    @(negedge clk);
    address = 16'h0002;
    #1;
    check("pre_reset_0002", data_out, 8'hCD);
    address = 16'h0005;
    data_in = 8'hEE;
    we      = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", data_out, 8'h00);
    @(posedge clk);
    #1;
    we = 1'b0;
    keys.delete();
    foreach (model[k]) keys.push_back(k);
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    read_check("discarded_write_0005", 16'h0005);
    foreach (keys[i]) read_check("cleared", 16'(keys[i]));

    // First edge after release accepts a write.
    write(16'h0001, 8'h3C);
    read_check("post_reset_write", 16'h0001);
    read_check("post_reset_0002", 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
